int_sequencer: RTL and testbench

Parametrised interrupt/reset entry sequencer for the 6502 core, the next-generation companion to the opcode-decode control FSM. At an instruction boundary it arbitrates RESET, NMI, BRK and up to N_IRQ maskable lines, then takes the memory bus to push PCH/PCL/P onto the stack page, fetches the 16-bit vector, sets the I flag and hands a new PC back to the core. It supports configurable memory wait states and 6502-style NMI hijack of an in-progress IRQ/BRK sequence.

---
 rtl/int_sequencer_pkg.sv | 41 ++++
 rtl/int_sequencer_irq_prio_enc.sv | 26 ++
 rtl/int_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_int_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_sequencer_pkg.sv
// Shared types and constants for the interrupt/reset entry sequencer.
package int_sequencer_pkg;

  // Sequencer states; a pending reset is tracked separately while in ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_P,
    ST_VEC_LO,
    ST_VEC_HI
  } int_state_t;

  // Kind of request being serviced, listed in priority order.
  typedef enum logic [1:0] {
    KIND_RESET,
    KIND_NMI,
    KIND_BRK,
    KIND_IRQ
  } int_kind_t;

  // Vector offsets relative to the NMI vector base.
  localparam logic [15:0] VEC_OFF_NMI   = 16'd0;
  localparam logic [15:0] VEC_OFF_RESET = 16'd2;
  localparam logic [15:0] VEC_OFF_IRQ   = 16'd4;

  // Processor status bit positions.
  localparam int P_BIT_I = 2;
  localparam int P_BIT_B = 4;
  localparam int P_BIT_U = 5;

  // Status byte as written to the stack: U forced high, B reflects BRK.
  function automatic logic [7:0] push_p(input logic [7:0] p, input logic is_brk);
    logic [7:0] r;
    r          = p;
    r[P_BIT_U] = 1'b1;
    r[P_BIT_B] = is_brk;
    return r;
  endfunction

endpackage

// File: rtl/int_sequencer_irq_prio_enc.sv
// Masked lowest-index priority encoder for the maskable IRQ lines.
module irq_prio_enc
  import int_sequencer_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top down so the lowest active index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && en_i) begin
        valid_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt/reset entry sequencer: arbitrates RESET/NMI/BRK/IRQ at an
// instruction boundary, pushes PC and P, fetches the vector and hands the
// new PC back to the core.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int          N_IRQ       = 4,
  parameter logic [15:0] VEC_BASE    = 16'hFFFA,
  parameter logic [7:0]  STACK_PAGE  = 8'h01,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 instr_boundary,
  input  logic                                 brk_req,
  input  logic                                 nmi_n,
  input  logic [N_IRQ-1:0]                     irq_n,
  input  logic [7:0]                           p_in,
  input  logic [7:0]                           s_in,
  input  logic [15:0]                          pc_in,
  input  logic [7:0]                           mem_rdata,
  output logic                                 take,
  output logic [15:0]                          addr,
  output logic [7:0]                           wdata,
  output logic                                 mem_rw,
  output logic                                 s_dec,
  output logic                                 pc_ld,
  output logic [15:0]                          pc_out,
  output logic                                 i_set,
  output logic [((N_IRQ > 1) ? $clog2(N_IRQ) : 1)-1:0] irq_src,
  output logic                                 done
);

  localparam int IRQ_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  int_state_t       state_q, state_d;
  int_kind_t        kind_q, kind_d;
  logic [3:0]       wait_q, wait_d;
  logic             reset_pend_q, reset_pend_d;
  logic             nmi_prev_q;
  logic             nmi_pend_q, nmi_pend_d;
  logic [15:0]      vec_q, vec_d;
  logic [7:0]       vec_lo_q, vec_lo_d;
  logic [15:0]      pc_out_q, pc_out_d;
  logic [IRQ_W-1:0] irq_src_q, irq_src_d;

  logic             irq_valid;
  logic [IRQ_W-1:0] irq_idx;
  logic             last;
  logic             nmi_fall;

  irq_prio_enc #(
    .N  (N_IRQ),
    .IW (IRQ_W)
  ) u_prio (
    .req_i   (~irq_n),
    .en_i    (~p_in[P_BIT_I]),
    .valid_o (irq_valid),
    .idx_o   (irq_idx)
  );

  // Final cycle of the current bus state; strobes fire and the state advances here.
  assign last     = (wait_q == 4'(WAIT_CYCLES));
  assign nmi_fall = nmi_prev_q & ~nmi_n;
  assign irq_src  = irq_src_q;

  // Next-state logic and bus outputs.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    wait_d       = wait_q;
    reset_pend_d = reset_pend_q;
    vec_d        = vec_q;
    vec_lo_d     = vec_lo_q;
    pc_out_d     = pc_out_q;
    irq_src_d    = irq_src_q;
    nmi_pend_d   = nmi_pend_q;

    take   = 1'b0;
    addr   = '0;
    wdata  = '0;
    mem_rw = 1'b1;
    s_dec  = 1'b0;
    pc_ld  = 1'b0;
    pc_out = pc_out_q;
    i_set  = 1'b0;
    done   = 1'b0;

    // Servicing the NMI vector consumes the latched edge; a fresh edge still wins.
    if (state_q == ST_VEC_LO && vec_q == VEC_BASE + VEC_OFF_NMI) nmi_pend_d = 1'b0;
    if (nmi_fall) nmi_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (reset_pend_q || (instr_boundary && (nmi_pend_q || brk_req || irq_valid))) begin
          state_d      = ST_PUSH_PCH;
          wait_d       = '0;
          reset_pend_d = 1'b0;
          if (reset_pend_q) begin
            kind_d = KIND_RESET;
            vec_d  = VEC_BASE + VEC_OFF_RESET;
          end else if (nmi_pend_q) begin
            kind_d = KIND_NMI;
            vec_d  = VEC_BASE + VEC_OFF_NMI;
          end else if (brk_req) begin
            kind_d = KIND_BRK;
            vec_d  = VEC_BASE + VEC_OFF_IRQ;
          end else begin
            kind_d    = KIND_IRQ;
            vec_d     = VEC_BASE + VEC_OFF_IRQ;
            irq_src_d = irq_idx;
          end
        end
      end

      ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P: begin
        take   = 1'b1;
        addr   = {STACK_PAGE, s_in};
        mem_rw = (kind_q == KIND_RESET);
        s_dec  = last;
        if (state_q == ST_PUSH_PCH)      wdata = pc_in[15:8];
        else if (state_q == ST_PUSH_PCL) wdata = pc_in[7:0];
        else                             wdata = push_p(p_in, kind_q == KIND_BRK);
        if (last) begin
          wait_d = '0;
          if (state_q == ST_PUSH_PCH)      state_d = ST_PUSH_PCL;
          else if (state_q == ST_PUSH_PCL) state_d = ST_PUSH_P;
          else begin
            state_d = ST_VEC_LO;
            // A pending NMI hijacks an IRQ/BRK sequence before its vector fetch.
            if (nmi_pend_q && (kind_q == KIND_IRQ || kind_q == KIND_BRK))
              vec_d = VEC_BASE + VEC_OFF_NMI;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      ST_VEC_LO: begin
        take = 1'b1;
        addr = vec_q;
        if (last) begin
          wait_d   = '0;
          vec_lo_d = mem_rdata;
          state_d  = ST_VEC_HI;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      ST_VEC_HI: begin
        take = 1'b1;
        addr = vec_q + 16'd1;
        if (last) begin
          wait_d   = '0;
          pc_out   = {mem_rdata, vec_lo_q};
          pc_out_d = {mem_rdata, vec_lo_q};
          pc_ld    = 1'b1;
          i_set    = 1'b1;
          done     = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset arms a pending RESET sequence.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      kind_q       <= KIND_RESET;
      wait_q       <= '0;
      reset_pend_q <= 1'b1;
      nmi_prev_q   <= 1'b1;
      nmi_pend_q   <= 1'b0;
      vec_q        <= '0;
      vec_lo_q     <= '0;
      pc_out_q     <= '0;
      irq_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      wait_q       <= wait_d;
      reset_pend_q <= reset_pend_d;
      nmi_prev_q   <= nmi_n;
      nmi_pend_q   <= nmi_pend_d;
      vec_q        <= vec_d;
      vec_lo_q     <= vec_lo_d;
      pc_out_q     <= pc_out_d;
      irq_src_q    <= irq_src_d;
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed testbench for int_sequencer: one instance with no wait states,
// one with two wait states per bus state.
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        instr_boundary = 1'b0;
  logic        brk_req = 1'b0;
  logic        nmi_n = 1'b1;
  logic [3:0]  irq_n = 4'hF;
  logic [7:0]  p_in = 8'h00;
  logic [15:0] pc_in = 16'h0000;

  logic        rst0 = 1'b1, rst2 = 1'b1;
  logic [7:0]  s0_base = 8'hFF, s2_base = 8'hFF;
  logic [7:0]  s0_cnt = 8'd0, s2_cnt = 8'd0;
  logic [7:0]  s_in0, s_in2, mem_rdata0, mem_rdata2;

  logic        take0, mem_rw0, s_dec0, pc_ld0, i_set0, done0;
  logic [15:0] addr0, pc_out0;
  logic [7:0]  wdata0;
  logic [1:0]  irq_src0;
  logic        take2, mem_rw2, s_dec2, pc_ld2, i_set2, done2;
  logic [15:0] addr2, pc_out2;
  logic [7:0]  wdata2;
  logic [1:0]  irq_src2;

  logic [7:0]  mem [0:65535];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Core-side stack pointer: each s_dec strobe decrements S at the clock edge.
  always @(posedge clk) begin
    if (s_dec0) s0_cnt <= s0_cnt + 8'd1;
    if (s_dec2) s2_cnt <= s2_cnt + 8'd1;
  end

  assign s_in0      = s0_base - s0_cnt;
  assign s_in2      = s2_base - s2_cnt;
  assign mem_rdata0 = mem[addr0];
  assign mem_rdata2 = mem[addr2];

  int_sequencer #(.N_IRQ(4), .VEC_BASE(16'hFFFA), .STACK_PAGE(8'h01), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .instr_boundary(instr_boundary), .brk_req(brk_req),
    .nmi_n(nmi_n), .irq_n(irq_n), .p_in(p_in), .s_in(s_in0), .pc_in(pc_in),
    .mem_rdata(mem_rdata0), .take(take0), .addr(addr0), .wdata(wdata0),
    .mem_rw(mem_rw0), .s_dec(s_dec0), .pc_ld(pc_ld0), .pc_out(pc_out0),
    .i_set(i_set0), .irq_src(irq_src0), .done(done0)
  );

  int_sequencer #(.N_IRQ(4), .VEC_BASE(16'hFFFA), .STACK_PAGE(8'h01), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2), .instr_boundary(instr_boundary), .brk_req(brk_req),
    .nmi_n(nmi_n), .irq_n(irq_n), .p_in(p_in), .s_in(s_in2), .pc_in(pc_in),
    .mem_rdata(mem_rdata2), .take(take2), .addr(addr2), .wdata(wdata2),
    .mem_rw(mem_rw2), .s_dec(s_dec2), .pc_ld(pc_ld2), .pc_out(pc_out2),
    .i_set(i_set2), .irq_src(irq_src2), .done(done2)
  );

  task automatic test_reset();
    logic [15:0] ea [5];
    ea = '{16'h01FD, 16'h01FC, 16'h01FB, 16'hFFFC, 16'hFFFD};
    rst0 = 1'b1;
    rst2 = 1'b1;
    s0_base = 8'hFD + s0_cnt;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({take0, addr0, wdata0, mem_rw0, s_dec0, pc_ld0, pc_out0, i_set0, irq_src0, done0} !==
        {1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: take=%b addr=%h wdata=%h rw=%b s_dec=%b pc_ld=%b pc_out=%h i_set=%b irq_src=%0d done=%b, expected 0/0000/00/1/0/0/0000/0/0/0",
               take0, addr0, wdata0, mem_rw0, s_dec0, pc_ld0, pc_out0, i_set0, irq_src0, done0);
    end
    rst0 = 1'b0;
    vectors++;
    if (take0 !== 1'b0 || mem_rw0 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_exit_cycle: take=%b rw=%b, expected take=0 rw=1", take0, mem_rw0);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (take0 !== 1'b1 || addr0 !== ea[k] || mem_rw0 !== 1'b1 || s_dec0 !== (k < 3) ||
          done0 !== (k == 4) || pc_ld0 !== (k == 4) || i_set0 !== (k == 4) ||
          (k == 4 && pc_out0 !== 16'hC000)) begin
        miscompares++;
        $display("FAIL reset_seq state %0d: take=%b addr=%h rw=%b s_dec=%b done=%b pc_out=%h, expected addr=%h rw=1 pc_out=C000 at end",
                 k, take0, addr0, mem_rw0, s_dec0, done0, pc_out0, ea[k]);
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (take0 !== 1'b0 || done0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_return_idle: take=%b done=%b, expected 0/0", take0, done0);
    end
  endtask

  task automatic test_irq();
    logic [15:0] ea [5];
    logic [7:0]  ew [5];
    logic        er [5];
    ea = '{16'h01FF, 16'h01FE, 16'h01FD, 16'hFFFE, 16'hFFFF};
    ew = '{8'h12, 8'h34, 8'h20, 8'h00, 8'h00};
    er = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    s0_base = 8'hFF + s0_cnt;
    irq_n = 4'b1011;
    p_in = 8'h20;
    pc_in = 16'h1234;
    instr_boundary = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      instr_boundary = 1'b0;
      vectors++;
      if (take0 !== 1'b1 || addr0 !== ea[k] || mem_rw0 !== er[k] || s_dec0 !== (k < 3) ||
          done0 !== (k == 4) || pc_ld0 !== (k == 4) || i_set0 !== (k == 4) ||
          (er[k] == 1'b0 && wdata0 !== ew[k]) || (k == 4 && pc_out0 !== 16'hF000)) begin
        miscompares++;
        $display("FAIL irq_seq state %0d: take=%b addr=%h rw=%b wdata=%h s_dec=%b done=%b pc_out=%h, expected addr=%h rw=%b wdata=%h",
                 k, take0, addr0, mem_rw0, wdata0, s_dec0, done0, pc_out0, ea[k], er[k], ew[k]);
      end
    end
    irq_n = 4'hF;
    @(posedge clk);
    #1;
    vectors++;
    if (take0 !== 1'b0 || irq_src0 !== 2'd2) begin
      miscompares++;
      $display("FAIL irq_src: take=%b irq_src=%0d, expected take=0 irq_src=2", take0, irq_src0);
    end
  endtask

  task automatic test_masked_irq();
    irq_n = 4'b0110;
    p_in = 8'h24;
    instr_boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (take0 !== 1'b0) begin
        miscompares++;
        $display("FAIL masked_irq cycle %0d: take=%b, expected 0", i, take0);
      end
    end
    instr_boundary = 1'b0;
    irq_n = 4'hF;
  endtask

  task automatic test_brk();
    logic [15:0] ea [5];
    logic [7:0]  ew [5];
    logic        er [5];
    ea = '{16'h01FF, 16'h01FE, 16'h01FD, 16'hFFFE, 16'hFFFF};
    ew = '{8'h03, 8'h02, 8'h30, 8'h00, 8'h00};
    er = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    s0_base = 8'hFF + s0_cnt;
    p_in = 8'h00;
    pc_in = 16'h0302;
    brk_req = 1'b1;
    instr_boundary = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      instr_boundary = 1'b0;
      brk_req = 1'b0;
      vectors++;
      if (take0 !== 1'b1 || addr0 !== ea[k] || mem_rw0 !== er[k] || s_dec0 !== (k < 3) ||
          done0 !== (k == 4) || pc_ld0 !== (k == 4) || i_set0 !== (k == 4) ||
          (er[k] == 1'b0 && wdata0 !== ew[k]) || (k == 4 && pc_out0 !== 16'hF000)) begin
        miscompares++;
        $display("FAIL brk_seq state %0d: take=%b addr=%h rw=%b wdata=%h s_dec=%b done=%b pc_out=%h, expected addr=%h rw=%b wdata=%h",
                 k, take0, addr0, mem_rw0, wdata0, s_dec0, done0, pc_out0, ea[k], er[k], ew[k]);
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (take0 !== 1'b0 || irq_src0 !== 2'd2) begin
      miscompares++;
      $display("FAIL brk_irq_src_hold: take=%b irq_src=%0d, expected take=0 irq_src=2", take0, irq_src0);
    end
  endtask

  task automatic test_nmi_hijack();
    logic [15:0] ea [5];
    logic [7:0]  ew [5];
    logic        er [5];
    ea = '{16'h01FF, 16'h01FE, 16'h01FD, 16'hFFFA, 16'hFFFB};
    ew = '{8'h45, 8'h67, 8'h20, 8'h00, 8'h00};
    er = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    s0_base = 8'hFF + s0_cnt;
    irq_n = 4'b1110;
    p_in = 8'h20;
    pc_in = 16'h4567;
    instr_boundary = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      instr_boundary = 1'b0;
      vectors++;
      if (take0 !== 1'b1 || addr0 !== ea[k] || mem_rw0 !== er[k] || s_dec0 !== (k < 3) ||
          done0 !== (k == 4) || pc_ld0 !== (k == 4) || i_set0 !== (k == 4) ||
          (er[k] == 1'b0 && wdata0 !== ew[k]) || (k == 4 && pc_out0 !== 16'hE000)) begin
        miscompares++;
        $display("FAIL nmi_hijack state %0d: take=%b addr=%h rw=%b wdata=%h s_dec=%b done=%b pc_out=%h, expected addr=%h rw=%b wdata=%h",
                 k, take0, addr0, mem_rw0, wdata0, s_dec0, done0, pc_out0, ea[k], er[k], ew[k]);
      end
      if (k == 1) nmi_n = 1'b0;
    end
    irq_n = 4'hF;
    @(posedge clk);
    #1;
    vectors++;
    if (irq_src0 !== 2'd0) begin
      miscompares++;
      $display("FAIL nmi_hijack_irq_src: irq_src=%0d, expected 0", irq_src0);
    end
    // The NMI edge was consumed by the hijack, so nothing is pending now.
    instr_boundary = 1'b1;
    @(posedge clk);
    #1;
    instr_boundary = 1'b0;
    vectors++;
    if (take0 !== 1'b0) begin
      miscompares++;
      $display("FAIL nmi_pend_cleared: take=%b, expected 0", take0);
    end
  endtask

  task automatic test_wait_states();
    logic [15:0] ea [5];
    logic [7:0]  ew [5];
    logic        er [5];
    int          done_at;
    logic [15:0] pc_seen;
    ea = '{16'h01FF, 16'h01FE, 16'h01FD, 16'hFFFA, 16'hFFFB};
    ew = '{8'hAB, 8'hCD, 8'h24, 8'h00, 8'h00};
    er = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // RESET sequence with two wait states: done 15 cycles after acceptance.
    nmi_n = 1'b1;
    s2_base = 8'hFD + s2_cnt;
    rst2 = 1'b0;
    done_at = 0;
    pc_seen = 16'h0000;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done2 === 1'b1 && done_at == 0) begin
        done_at = i;
        pc_seen = pc_out2;
      end
    end
    vectors++;
    if (done_at != 15 || pc_seen !== 16'hC000) begin
      miscompares++;
      $display("FAIL wait_reset_done: done at cycle %0d pc_out=%h, expected cycle 15 pc_out=C000", done_at, pc_seen);
    end

    // NMI with two wait states: every bus state held three cycles.
    nmi_n = 1'b0;
    @(posedge clk);
    #1;
    s2_base = 8'hFF + s2_cnt;
    pc_in = 16'hABCD;
    p_in = 8'h04;
    instr_boundary = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        instr_boundary = 1'b0;
        vectors++;
        if (take2 !== 1'b1 || addr2 !== ea[k] || mem_rw2 !== er[k] || s_dec2 !== (k < 3 && c == 2) ||
            done2 !== (k == 4 && c == 2) || pc_ld2 !== (k == 4 && c == 2) || i_set2 !== (k == 4 && c == 2) ||
            (er[k] == 1'b0 && wdata2 !== ew[k]) || (k == 4 && c == 2 && pc_out2 !== 16'hE000)) begin
          miscompares++;
          $display("FAIL wait_nmi state %0d cycle %0d: take=%b addr=%h rw=%b wdata=%h s_dec=%b done=%b pc_out=%h, expected addr=%h rw=%b wdata=%h",
                   k, c, take2, addr2, mem_rw2, wdata2, s_dec2, done2, pc_out2, ea[k], er[k], ew[k]);
        end
      end
    end

    // Second NMI aborted by reset in PUSH_P.
    nmi_n = 1'b1;
    @(posedge clk);
    #1;
    nmi_n = 1'b0;
    @(posedge clk);
    #1;
    s2_base = 8'hFF + s2_cnt;
    instr_boundary = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      instr_boundary = 1'b0;
    end
    vectors++;
    if (take2 !== 1'b1 || addr2 !== 16'h01FD || mem_rw2 !== 1'b0 || wdata2 !== 8'h24) begin
      miscompares++;
      $display("FAIL wait_push_p: take=%b addr=%h rw=%b wdata=%h, expected 1/01FD/0/24", take2, addr2, mem_rw2, wdata2);
    end
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({take2, addr2, mem_rw2, s_dec2, pc_ld2, pc_out2, i_set2, done2} !==
        {1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_seq_reset: take=%b addr=%h rw=%b s_dec=%b pc_ld=%b pc_out=%h i_set=%b done=%b, expected 0/0000/1/0/0/0000/0/0",
               take2, addr2, mem_rw2, s_dec2, pc_ld2, pc_out2, i_set2, done2);
    end
    rst2 = 1'b0;
    nmi_n = 1'b1;
    s2_base = 8'hFD + s2_cnt;
    @(posedge clk);
    #1;
    vectors++;
    if (take2 !== 1'b1 || addr2 !== 16'h01FD || mem_rw2 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_restart: take=%b addr=%h rw=%b, expected 1/01FD/1", take2, addr2, mem_rw2);
    end
    done_at = 0;
    pc_seen = 16'h0000;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done2 === 1'b1 && done_at == 0) begin
        done_at = i;
        pc_seen = pc_out2;
      end
    end
    vectors++;
    if (done_at != 15 || pc_seen !== 16'hC000) begin
      miscompares++;
      $display("FAIL reset_restart_done: done at cycle %0d pc_out=%h, expected cycle 15 pc_out=C000", done_at, pc_seen);
    end
  endtask

  initial begin
    mem[16'hFFFA] = 8'h00;
    mem[16'hFFFB] = 8'hE0;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'hC0;
    mem[16'hFFFE] = 8'h00;
    mem[16'hFFFF] = 8'hF0;
    test_reset();
    test_irq();
    test_masked_irq();
    test_brk();
    test_nmi_hijack();
    test_wait_states();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
